// File: rtl/queue_sensor_conditioner.sv
// Photo-beam front end: per-beam sync + debounce FSM, one registered count pulse per passage.
// Optional stuck-beam detection is built when SBQM_STUCK_DET_EN is defined.

module qsc_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int STUCK_CYCLES    = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic fire,
  output logic stuck
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] HELD = 2'd2;
  localparam logic [1:0] REL  = 2'd3;
  localparam logic [CNT_W:0] DEB = (CNT_W+1)'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             s;
  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W:0]   cnt_inc;
  logic             done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], x};
  end
  assign s = sync_q[1];

  // Widened increment so the compare against DEB can never be fooled by wrap.
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign done    = (cnt_inc == DEB);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    case (state)
      IDLE: if (!s) begin
        if (DEB == 1) begin
          state_n = HELD;
          cnt_n   = '0;
          fire    = 1'b1;
        end else begin
          state_n = ARM;
          cnt_n   = CNT_W'(1);
        end
      end
      ARM: if (s) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else if (done) begin
        state_n = HELD;
        cnt_n   = '0;
        fire    = 1'b1;
      end else begin
        cnt_n   = cnt_inc[CNT_W-1:0];
      end
      HELD: if (s) begin
        if (DEB == 1) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          state_n = REL;
          cnt_n   = CNT_W'(1);
        end
      end
      default: if (!s) begin
        state_n = HELD;
        cnt_n   = '0;
      end else if (done) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n   = cnt_inc[CNT_W-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

`ifdef SBQM_STUCK_DET_EN
  localparam logic [7:0] STK = 8'(STUCK_CYCLES);
  logic [7:0] dwell;

  // Counts edges spent in HELD/REL; clears on the edge that returns to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell <= '0;
      stuck <= 1'b0;
    end else if ((state == HELD || state == REL) && state_n != IDLE) begin
      if (dwell != STK) dwell <= dwell + 8'd1;
      if (dwell + 8'd1 == STK) stuck <= 1'b1;
    end else begin
      dwell <= '0;
      stuck <= 1'b0;
    end
  end
`else
  assign stuck = 1'b0;
`endif

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1 ||
      STUCK_CYCLES < 1 || STUCK_CYCLES > 255) begin : g_bad_param
    $error("queue_sensor_conditioner: parameter out of range");
  end
endmodule

module queue_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int STUCK_CYCLES    = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic x1,
  input  logic x2,
  output logic in1,
  output logic in2,
  output logic stuck1,
  output logic stuck2
);
  logic [1:0] beam, fire, stuck;
  logic       pend;

  assign beam = {x2, x1};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    qsc_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .x    (beam[i]),
      .fire (fire[i]),
      .stuck(stuck[i])
    );
  end

  // Entry wins a same-edge collision; exit is deferred one cycle via pend.
  // A channel cannot re-fire within 2*DEBOUNCE_CYCLES, so pend never collides.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in1  <= 1'b0;
      in2  <= 1'b0;
      pend <= 1'b0;
    end else begin
      in1  <= fire[0];
      in2  <= pend | (fire[1] & ~fire[0]);
      pend <= fire[0] & fire[1];
    end
  end

  assign stuck1 = stuck[0];
  assign stuck2 = stuck[1];
endmodule

// File: tb/tb_queue_sensor_conditioner.sv
// Directed-vector bench: stimulus pushes expected pulses (channel, cycle); a monitor pops on each pulse.
// Stuck-flag expectations follow SBQM_STUCK_DET_EN.

module tb_queue_sensor_conditioner;
  typedef struct { int ch; int cyc; } exp_t;

  logic clk = 1'b0;
  logic reset, x1, x2;
  logic in1, in2, stuck1, stuck2;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

`ifdef SBQM_STUCK_DET_EN
  localparam int STK_ON = 1;
`else
  localparam int STK_ON = 0;
`endif

  queue_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .STUCK_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .x1(x1), .x2(x2),
    .in1(in1), .in2(in2), .stuck1(stuck1), .stuck2(stuck2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int ch, input int at);
    exp_t e;
    e.ch = ch;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (in1 && in2) check("in1_in2_exclusive", 1, 0);
    if (in1 || in2) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse_ch", in1 ? 1 : 2, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_channel", in1 ? 1 : 2, e.ch);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int r, m;
    reset = 1'b0; x1 = 1'b1; x2 = 1'b1;
    #1;
    check("reset_in1", in1, 0);
    check("reset_in2", in2, 0);
    check("reset_stuck1", stuck1, 0);
    check("reset_stuck2", stuck2, 0);
    step(2);
    reset = 1'b1;
    step(20);

    // single entry
    x1 = 1'b0; push(1, cyc + 6);
    step(10); x1 = 1'b1; step(12);

    // glitches of 3 samples rejected, 4 samples accepted
    repeat (2) begin
      x1 = 1'b0; step(3); x1 = 1'b1; step(8);
    end
    x1 = 1'b0; push(1, cyc + 6);
    step(4); x1 = 1'b1; step(12);

    // simultaneous entry and exit
    x1 = 1'b0; x2 = 1'b0;
    push(1, cyc + 6); push(2, cyc + 7);
    step(10); x1 = 1'b1; x2 = 1'b1; step(12);

    // chatter while held
    x2 = 1'b0; push(2, cyc + 6);
    step(10); x2 = 1'b1; step(2); x2 = 1'b0; step(10); x2 = 1'b1; step(12);

    // reset while in ARM, release with beam still blocked
    x1 = 1'b0; step(4);
    reset = 1'b0;
    #1;
    check("midreset_in1", in1, 0);
    check("midreset_in2", in2, 0);
    check("midreset_stuck1", stuck1, 0);
    step(3);
    reset = 1'b1; r = cyc;
    push(1, r + 6);
    step(15);
    check("stuck1_before", stuck1, 0);
    step(1);
    check("stuck1_rise", stuck1, STK_ON);
    step(4);
    check("stuck1_hold", stuck1, STK_ON);
    check("stuck2_idle", stuck2, 0);
    x1 = 1'b1; m = cyc;
    step(5);
    check("stuck1_in_rel", stuck1, STK_ON);
    step(1);
    check("stuck1_clear", stuck1, 0);
    step(10);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("missing_pulse_ch", 0, e.ch);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
